seven_seg_frame_decoder: RTL and testbench

Receive-side counterpart of the two-digit time-multiplexed seven-segment driver. Monitors the shared 7-bit segment bus and the digit-select line, waits for each digit phase to settle, and captures the raw patterns. Decodes each pattern back to a 4-bit hex nibble and presents a complete byte with a one-cycle valid strobe. Used in self-check and loopback paths, and as a display-scraping front end.

---
 rtl/seven_seg_pkg.sv | 25 ++
 rtl/seg7_to_hex.sv | 22 ++
 rtl/seven_seg_frame_decoder.sv | 170 +++++++++++++++++
 tb/tb_seven_seg_frame_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment frame decoder: segment bit order,
// hex pattern table and FSM state encodings.
package seven_seg_pkg;

  // Segment bus order is {g,f,e,d,c,b,a}; a is bit 0.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_G = 6;
  localparam int unsigned SEG_W = SEG_G - SEG_A + 1;

  // Active-high pattern for each nibble value; entry i encodes hex digit i.
  localparam logic [15:0][SEG_W-1:0] HEX_PATTERN = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef logic [2:0] state_t;

  localparam state_t SYNC      = 3'd0;
  localparam state_t HI_SETTLE = 3'd1;
  localparam state_t HI_HOLD   = 3'd2;
  localparam state_t LO_SETTLE = 3'd3;
  localparam state_t EMIT      = 3'd4;
  localparam state_t HI_WAIT   = 3'd5;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of a seven-segment pattern to its hex nibble;
// unknown patterns report nibble 0 with valid_c low.
module seg7_to_hex
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic             valid_c,
  output logic [3:0]       nibble_c
);

  always_comb begin
    valid_c  = 1'b0;
    nibble_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == HEX_PATTERN[i]) begin
        valid_c  = 1'b1;
        nibble_c = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_frame_decoder.sv
// Recovers a byte from a two-digit multiplexed seven-segment bus.
// Optional SEG_ERR_COUNT_EN adds a saturating count of frames with bad patterns.
module seven_seg_frame_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 400000,
  parameter int unsigned TBITS       = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] segment,
  input  logic             digit_select,
  output logic [13:0]      raw_pair,
  output logic [7:0]       value,
  output logic             value_valid,
  output logic             pattern_err,
  output logic             stale
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int unsigned SCW = $clog2(STABLE_CYC + 1);

  logic             sel_q, sel_qq;
  logic [SEG_W-1:0] seg_q, seg_qq;
  state_t           state, state_n;
  logic [SCW-1:0]   stable, stable_n;
  logic [TBITS-1:0] tcnt, tcnt_n;
  logic [SEG_W-1:0] hi_pat, hi_pat_n, lo_pat, lo_pat_n;
  logic [13:0]      raw_pair_n;
  logic [7:0]       value_n;
  logic             value_valid_n, pattern_err_n, stale_n;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0]       err_count_n;
`endif

  logic       hi_ok_c, lo_ok_c;
  logic [3:0] hi_nib_c, lo_nib_c;
  logic       edge_c, rise_c, same_c, settled_c, timeout_c;

  seg7_to_hex u_hi_dec (.pattern(hi_pat), .valid_c(hi_ok_c), .nibble_c(hi_nib_c));
  seg7_to_hex u_lo_dec (.pattern(lo_pat), .valid_c(lo_ok_c), .nibble_c(lo_nib_c));

  assign edge_c    = sel_q ^ sel_qq;
  assign rise_c    = sel_q & ~sel_qq;
  assign same_c    = (seg_q == seg_qq);
  assign settled_c = same_c && (stable == SCW'(STABLE_CYC - 1));

  // Link-activity watchdog: restarts on every select edge, parks at TIMEOUT_CYC.
  always_comb begin
    if (edge_c)                             tcnt_n = '0;
    else if (tcnt == TBITS'(TIMEOUT_CYC))   tcnt_n = tcnt;
    else                                    tcnt_n = tcnt + TBITS'(1);
  end
  assign timeout_c = !edge_c && (tcnt_n == TBITS'(TIMEOUT_CYC));

  always_comb begin
    state_n       = state;
    stable_n      = stable;
    hi_pat_n      = hi_pat;
    lo_pat_n      = lo_pat;
    raw_pair_n    = raw_pair;
    value_n       = value;
    value_valid_n = 1'b0;
    pattern_err_n = pattern_err;
    stale_n       = edge_c ? 1'b0 : stale;
`ifdef SEG_ERR_COUNT_EN
    err_count_n   = err_count;
`endif

    if (timeout_c) begin
      state_n  = SYNC;
      stable_n = '0;
      stale_n  = 1'b1;
    end else begin
      case (state)
        SYNC, HI_WAIT: begin
          if (rise_c) begin
            state_n  = HI_SETTLE;
            stable_n = '0;
          end
        end
        HI_SETTLE, LO_SETTLE: begin
          // An edge before capture aborts the frame; a rising edge starts a new one.
          if (edge_c) begin
            state_n  = rise_c ? HI_SETTLE : SYNC;
            stable_n = '0;
          end else if (settled_c) begin
            stable_n = '0;
            if (state == HI_SETTLE) begin
              hi_pat_n = seg_q;
              state_n  = HI_HOLD;
            end else begin
              lo_pat_n = seg_q;
              state_n  = EMIT;
            end
          end else begin
            stable_n = same_c ? stable + SCW'(1) : '0;
          end
        end
        HI_HOLD: begin
          if (edge_c) begin
            state_n  = LO_SETTLE;
            stable_n = '0;
          end
        end
        EMIT: begin
          raw_pair_n    = {hi_pat, lo_pat};
          value_n       = {hi_nib_c, lo_nib_c};
          pattern_err_n = !(hi_ok_c && lo_ok_c);
          value_valid_n = 1'b1;
          state_n       = rise_c ? HI_SETTLE : HI_WAIT;
          stable_n      = '0;
`ifdef SEG_ERR_COUNT_EN
          if (!(hi_ok_c && lo_ok_c) && (err_count != 8'hFF))
            err_count_n = err_count + 8'd1;
`endif
        end
        default: begin
          state_n  = SYNC;
          stable_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= 1'b0;
      sel_qq      <= 1'b0;
      seg_q       <= '0;
      seg_qq      <= '0;
      state       <= SYNC;
      stable      <= '0;
      tcnt        <= '0;
      hi_pat      <= '0;
      lo_pat      <= '0;
      raw_pair    <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      stale       <= 1'b0;
`ifdef SEG_ERR_COUNT_EN
      err_count   <= '0;
`endif
    end else begin
      sel_q       <= digit_select;
      sel_qq      <= sel_q;
      seg_q       <= segment;
      seg_qq      <= seg_q;
      state       <= state_n;
      stable      <= stable_n;
      tcnt        <= tcnt_n;
      hi_pat      <= hi_pat_n;
      lo_pat      <= lo_pat_n;
      raw_pair    <= raw_pair_n;
      value       <= value_n;
      value_valid <= value_valid_n;
      pattern_err <= pattern_err_n;
      stale       <= stale_n;
`ifdef SEG_ERR_COUNT_EN
      err_count   <= err_count_n;
`endif
    end
  end

endmodule

// File: tb/tb_seven_seg_frame_decoder.sv
// Directed bench for seven_seg_frame_decoder (STABLE_CYC=4, TIMEOUT_CYC=50).
module tb_seven_seg_frame_decoder;
  import seven_seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  segment = 7'd0;
  logic        digit_select = 1'b0;
  logic [13:0] raw_pair;
  logic [7:0]  value;
  logic        value_valid;
  logic        pattern_err;
  logic        stale;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int s0;
  int base;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [6:0] enc [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_frame_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(50), .TBITS(6)) dut (
    .clk(clk), .rst(rst), .segment(segment), .digit_select(digit_select),
    .raw_pair(raw_pair), .value(value), .value_valid(value_valid),
    .pattern_err(pattern_err), .stale(stale)
`ifdef SEG_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (value_valid) begin
      strobes++;
      got_q.push_back(value);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic phase(input logic sel, input logic [6:0] seg, input int n);
    digit_select = sel;
    segment = seg;
    step(n);
  endtask

  initial begin
    logic [3:0] h, l;

    // Reset values
    step(3);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_raw", 32'(raw_pair), 32'h0);
    chk("rst_valid", 32'(value_valid), 32'h0);
    chk("rst_err", 32'(pattern_err), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    rst = 1'b0;
    step(2);

    // Frame 0x43 with exact strobe latency
    s0 = strobes;
    phase(1'b1, 7'h66, 20);
    digit_select = 1'b0;
    segment = 7'h4F;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("valid_early", 32'(value_valid), 32'h0);
    end
    step(1);
    chk("valid_at_latency", 32'(value_valid), 32'h1);
    chk("value_43", 32'(value), 32'h43);
    chk("raw_334f", 32'(raw_pair), 32'h334F);
    chk("err_clean", 32'(pattern_err), 32'h0);
    step(1);
    chk("valid_one_cycle", 32'(value_valid), 32'h0);
    chk("value_held", 32'(value), 32'h43);
    step(12);
    chk("strobes_f1", 32'(strobes - s0), 32'd1);

    // Blank low digit -> pattern error
    s0 = strobes;
    phase(1'b1, 7'h71, 20);
    phase(1'b0, 7'h00, 20);
    chk("value_f0", 32'(value), 32'hF0);
    chk("raw_3880", 32'(raw_pair), 32'h3880);
    chk("err_set", 32'(pattern_err), 32'h1);
    chk("strobes_f2", 32'(strobes - s0), 32'd1);
`ifdef SEG_ERR_COUNT_EN
    chk("err_count_1", 32'(err_count), 32'd1);
`endif

    // Select toggles before the high digit settles, then link goes quiet
    s0 = strobes;
    phase(1'b1, 7'h06, 3);
    phase(1'b0, 7'h06, 20);
    chk("short_no_strobe", 32'(strobes - s0), 32'd0);
    chk("short_value_hold", 32'(value), 32'hF0);
    chk("short_sync", 32'(dut.state), 32'(SYNC));
    step(25);
    chk("stale_before", 32'(stale), 32'h0);
    step(10);
    chk("stale_after", 32'(stale), 32'h1);
    chk("stale_value_hold", 32'(value), 32'hF0);
    chk("stale_raw_hold", 32'(raw_pair), 32'h3880);
    chk("stale_sync", 32'(dut.state), 32'(SYNC));

    // Recovery from stale
    s0 = strobes;
    phase(1'b1, 7'h7D, 2);
    chk("stale_cleared", 32'(stale), 32'h0);
    phase(1'b1, 7'h7D, 18);
    phase(1'b0, 7'h39, 20);
    chk("recover_value", 32'(value), 32'h6C);
    chk("recover_err", 32'(pattern_err), 32'h0);
    chk("recover_strobe", 32'(strobes - s0), 32'd1);
    chk("recover_stale", 32'(stale), 32'h0);

    // Reset in the middle of the low settle window
    s0 = strobes;
    phase(1'b1, 7'h5B, 20);
    digit_select = 1'b0;
    segment = 7'h4F;
    step(3);
    rst = 1'b1;
    step(1);
    chk("mid_rst_value", 32'(value), 32'h0);
    chk("mid_rst_raw", 32'(raw_pair), 32'h0);
    chk("mid_rst_valid", 32'(value_valid), 32'h0);
    chk("mid_rst_err", 32'(pattern_err), 32'h0);
    chk("mid_rst_stale", 32'(stale), 32'h0);
`ifdef SEG_ERR_COUNT_EN
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
`endif
    step(3);
    rst = 1'b0;
    step(20);
    chk("mid_rst_no_strobe", 32'(strobes - s0), 32'd0);
    chk("mid_rst_value_hold", 32'(value), 32'h0);

    // Random back-to-back valid frames
    s0 = strobes;
    base = got_q.size();
    for (int i = 0; i < 300; i++) begin
      h = 4'($urandom_range(15));
      l = 4'($urandom_range(15));
      exp_q.push_back({h, l});
      phase(1'b1, enc[h], int'($urandom_range(12, 6)));
      phase(1'b0, enc[l], int'($urandom_range(12, 7)));
    end
    chk("rand_strobes", 32'(strobes - s0), 32'd300);
    for (int i = 0; i < 300; i++) begin
      chk("rand_value", (base + i < got_q.size()) ? 32'(got_q[base + i]) : 32'hFFFF_FFFF,
          32'(exp_q[i]));
    end
    chk("rand_err", 32'(pattern_err), 32'h0);
    chk("rand_stale", 32'(stale), 32'h0);
`ifdef SEG_ERR_COUNT_EN
    chk("rand_err_count", 32'(err_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
